counter_sweep_ctrl: RTL and testbench

//   Sequencer that drives an up_down_counter through programmed triangle sweeps.

---
 rtl/counter_sweep_ctrl.sv | 120 ++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter: seek lo, ramp to hi, dwell, ramp to lo, dwell, repeat.
// cnt_en/cnt_up are decoded from state and count with no latency; abort wins over every transition.
module counter_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         cycles,
  input  logic [WIDTH-1:0]   count,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         sweep_cnt
);

  typedef enum logic [2:0] {
    IDLE, SEEK, UP, HOLD_HI, DOWN, HOLD_LO, DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_q, timer;
  logic [3:0]         cycles_q;
  logic [3:0]         sweep_inc;
  logic               accept, at_lo, at_hi;

  assign accept    = (state == IDLE) && start && (lo_lim < hi_lim);
  assign at_lo     = (count == lo_q);
  assign at_hi     = (count == hi_q);
  assign sweep_inc = (sweep_cnt == 4'hf) ? 4'hf : sweep_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SEEK;
      end
      SEEK: begin
        busy   = 1'b1;
        cnt_en = !at_lo;
        cnt_up = (count < lo_q);
        if (at_lo) state_nxt = UP;
      end
      UP: begin
        busy   = 1'b1;
        cnt_en = !at_hi;
        cnt_up = 1'b1;
        if (at_hi) state_nxt = HOLD_HI;
      end
      HOLD_HI: begin
        busy = 1'b1;
        if (timer == '0) state_nxt = DOWN;
      end
      DOWN: begin
        busy   = 1'b1;
        cnt_en = !at_lo;
        if (at_lo) begin
          if ((cycles_q != 4'd0) && (sweep_inc == cycles_q)) state_nxt = DONE;
          else                                               state_nxt = HOLD_LO;
        end
      end
      HOLD_LO: begin
        busy = 1'b1;
        if (timer == '0) state_nxt = UP;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort must also gate the counter in the same cycle, not just steer the FSM.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      dwell_q   <= '0;
      cycles_q  <= '0;
      timer     <= '0;
      sweep_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= (state == IDLE) && start && !(lo_lim < hi_lim);
      if (accept) begin
        lo_q      <= lo_lim;
        hi_q      <= hi_lim;
        dwell_q   <= dwell;
        cycles_q  <= cycles;
        sweep_cnt <= '0;
      end
      if ((state == DOWN) && at_lo && !abort) sweep_cnt <= sweep_inc;
      // Timer is loaded on the turn-point cycle so each hold lasts dwell+1 cycles.
      if (((state == UP) && (state_nxt == HOLD_HI)) || ((state == DOWN) && (state_nxt == HOLD_LO)))
        timer <= dwell_q;
      else if (((state == HOLD_HI) || (state == HOLD_LO)) && (timer != '0))
        timer <= timer - DWELL_W'(1);
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Randomized bench for counter_sweep_ctrl: a behavioural up/down counter plus a per-cycle trajectory model.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] lo_lim = '0, hi_lim = '0, dwell = '0, cycles = '0;
  logic [3:0] count;
  logic       cnt_en, cnt_up, busy, done, err;
  logic [3:0] sweep_cnt;
  logic       ld = 1'b0;
  logic [3:0] ld_val = '0;

  int n_chk = 0;
  int n_fail = 0;
  int last_sw = 0;
  int run_id = 0;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       busy;
    logic       done;
    logic [3:0] sw;
    logic [2:0] ph;   // 1 seek, 2 rise, 3 top dwell, 4 fall, 5 bottom dwell, 6 finish, 0 idle
  } exp_t;

  exp_t exp_q[$];

  counter_sweep_ctrl #(.WIDTH(4), .DWELL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .dwell(dwell), .cycles(cycles),
    .count(count), .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy),
    .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Attached up/down counter
  always @(posedge clk) begin
    if (ld)          count <= ld_val;
    else if (cnt_en) count <= cnt_up ? count + 4'd1 : count - 4'd1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string where, input exp_t e);
    chk({where, ".cnt_en"}, int'(cnt_en), int'(e.en));
    if (e.en) chk({where, ".cnt_up"}, int'(cnt_up), int'(e.up));
    chk({where, ".busy"}, int'(busy), int'(e.busy));
    chk({where, ".done"}, int'(done), int'(e.done));
    chk({where, ".err"}, int'(err), 0);
    chk({where, ".sweep_cnt"}, int'(sweep_cnt), int'(e.sw));
  endtask

  task automatic push(input bit en, input bit up, input bit bz, input bit dn, input int sw, input int ph);
    exp_t e;
    e.en = en; e.up = up; e.busy = bz; e.done = dn;
    e.sw = 4'(sw); e.ph = 3'(ph);
    exp_q.push_back(e);
  endtask

  // Cycle-by-cycle expected outputs of one run, starting the cycle after start is accepted.
  task automatic build(input int c0, input int lo, input int hi, input int dw, input int cyc, input int cap);
    int c, sw;
    c = c0;
    sw = 0;
    exp_q.delete();
    while (c != lo) begin
      push(1'b1, c < lo, 1'b1, 1'b0, sw, 1);
      c += (c < lo) ? 1 : -1;
    end
    push(1'b0, 1'b0, 1'b1, 1'b0, sw, 1);
    while (1) begin
      while (c != hi) begin push(1'b1, 1'b1, 1'b1, 1'b0, sw, 2); c++; end
      push(1'b0, 1'b1, 1'b1, 1'b0, sw, 2);
      repeat (dw + 1) push(1'b0, 1'b0, 1'b1, 1'b0, sw, 3);
      while (c != lo) begin push(1'b1, 1'b0, 1'b1, 1'b0, sw, 4); c--; end
      push(1'b0, 1'b0, 1'b1, 1'b0, sw, 4);
      sw = (sw == 15) ? 15 : sw + 1;
      if (cyc != 0 && sw == cyc) begin
        push(1'b0, 1'b0, 1'b0, 1'b1, sw, 6);
        break;
      end
      repeat (dw + 1) push(1'b0, 1'b0, 1'b1, 1'b0, sw, 5);
      if (exp_q.size() > cap) break;
    end
    push(1'b0, 1'b0, 1'b0, 1'b0, sw, 0);
  endtask

  // kill: 0 = run to completion, 1 = abort during a rise, 2 = reset during a fall
  task automatic run(input int c0, input int lo, input int hi, input int dw, input int cyc,
                     input int kill, input int cap);
    exp_t e;
    int   k;
    int   idx[$];
    run_id++;
    build(c0, lo, hi, dw, cyc, cap);
    k = -1;
    if (kill != 0) begin
      foreach (exp_q[i])
        if (i >= exp_q.size() / 2 && exp_q[i].en && int'(exp_q[i].ph) == ((kill == 1) ? 2 : 4))
          idx.push_back(i);
      if (idx.size() > 0) k = idx[$urandom_range(idx.size() - 1)];
    end
    @(negedge clk); ld = 1'b1; ld_val = 4'(c0);
    @(negedge clk); ld = 1'b0;
    lo_lim = 4'(lo); hi_lim = 4'(hi); dwell = 4'(dw); cycles = 4'(cyc); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (i == k && kill == 1) begin abort = 1'b1; start = 1'b0; e.en = 1'b0; end
      if (i == k && kill == 2) begin
        reset_n = 1'b0; start = 1'b0;
        e.en = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.sw = 4'd0;
      end
      #1;
      check_outs($sformatf("run%0d.cyc%0d", run_id, i), e);
      if (i == k) begin
        @(negedge clk);
        abort = 1'b0;
        reset_n = 1'b1;
        if (kill == 1) begin
          e.busy = 1'b0;
          #1;
          check_outs($sformatf("run%0d.post_abort", run_id), e);
          last_sw = int'(e.sw);
        end else begin
          last_sw = 0;
        end
        return;
      end
      // Mid-run input churn must be ignored, including start while busy.
      lo_lim = 4'($urandom); hi_lim = 4'($urandom);
      dwell = 4'($urandom); cycles = 4'($urandom);
      start = e.busy ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("run%0d.end_count", run_id), int'(count), lo);
    last_sw = int'(exp_q[exp_q.size() - 1].sw);
  endtask

  task automatic err_test(input int lo, input int hi);
    @(negedge clk); lo_lim = 4'(lo); hi_lim = 4'(hi); start = 1'b1;
    #1;
    chk("err.pre_edge", int'(err), 0);
    @(negedge clk); start = 1'b0;
    #1;
    chk("err.pulse", int'(err), 1);
    chk("err.busy", int'(busy), 0);
    chk("err.cnt_en", int'(cnt_en), 0);
    chk("err.sweep_cnt", int'(sweep_cnt), last_sw);
    @(negedge clk);
    #1;
    chk("err.clear", int'(err), 0);
    chk("err.busy2", int'(busy), 0);
  endtask

  initial begin
    int lo, hi;
    #12;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.cnt_en", int'(cnt_en), 0);
    chk("rst.sweep_cnt", int'(sweep_cnt), 0);
    @(negedge clk); reset_n = 1'b1;

    run(0, 2, 5, 1, 1, 0, 1000);
    err_test(5, 5);
    err_test(9, 3);
    run(12, 3, 9, $urandom_range(3), 1, 0, 1000);
    run($urandom_range(15), 0, 15, $urandom_range(2), 0, 1, 200);
    run($urandom_range(15), 1, 3, 0, 2, 0, 1000);
    run($urandom_range(15), 4, 7, 15, 2, 0, 1000);
    run(0, 0, 1, 0, 0, 1, 240);
    run(8, 2, 5, 1, 1, 2, 1000);
    run(0, 2, 5, 1, 1, 0, 1000);
    for (int r = 0; r < 20; r++) begin
      lo = $urandom_range(14);
      hi = $urandom_range(15, lo + 1);
      run($urandom_range(15), lo, hi, $urandom_range(3), $urandom_range(3, 1), (r % 3 == 0) ? 1 : 0, 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
